data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Sequences the MEM-stage data-memory port: req/gnt/rvalid handshake, byte-lane steering,
//  misalignment detection and load extraction/sign-extension. Sits between the MEM pipeline
//  stage and the data memory bus; stalls the pipeline while an access is outstanding.
//  One access in flight at a time.
// PARAMETERS
//  DATA_WIDTH  32  data/address width; only 32 is supported (4 byte lanes)
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_i           in   1   asynchronous reset, active-high
//  req_i           in   1   MEM stage requests an access; held stable while busy_o=1
//  we_i            in   1   1=store, 0=load
//  type_i          in   2   00=word, 01=halfword, 10=byte, 11=illegal
//  sign_ext_i      in   1   load result: 1=sign-extend, 0=zero-extend
//  addr_i          in   32  byte address
//  wdata_i         in   32  store data, right-aligned
//  rdata_o         out  32  extracted/extended load data; valid when valid_o=1
//  valid_o         out  1   access complete this cycle (load or store)
//  busy_o          out  1   stall: access accepted/outstanding, not completing this cycle
//  err_o           out  1   misaligned/illegal access; one-cycle pulse, no bus request made
//  data_req_o      out  1   bus request
//  data_gnt_i      in   1   bus grant; address phase ends on req&gnt
//  data_rvalid_i   in   1   response valid (loads and stores)
//  data_addr_o     out  32  word address {addr[31:2],2'b00}
//  data_we_o       out  1   bus write enable
//  data_be_o       out  4   byte enables
//  data_wdata_o    out  32  lane-replicated store data
//  data_rdata_i    in   32  bus read data
// BEHAVIOUR
//  Reset: while rst_i=1, state=IDLE and every output is forced to 0.
//  FSM states IDLE, WAIT_GNT, WAIT_RVALID.
//   IDLE: req_i & aligned -> data_req_o=1 combinationally from inputs; latch we, type,
//     sign_ext, offset addr[1:0], be, wdata, addr. gnt=1 -> WAIT_RVALID, else -> WAIT_GNT.
//     req_i & misaligned -> err_o=1 this cycle, busy_o=0, stay IDLE, no bus activity.
//   WAIT_GNT: data_req_o=1, bus outputs from latched regs (stable until gnt); req_i ignored;
//     gnt=1 -> WAIT_RVALID.
//   WAIT_RVALID: data_req_o=0; on rvalid: valid_o=1, rdata_o driven, -> IDLE.
//  When data_req_o=0, data_addr_o, data_we_o, data_be_o and data_wdata_o are 0.
//  busy_o = (IDLE & req_i & aligned) | WAIT_GNT | (WAIT_RVALID & ~rvalid).
//  Minimum latency: req in cycle 0 with gnt, rvalid in cycle 1 -> valid_o in cycle 1.
//  One idle cycle follows every completion (the next request is accepted only in IDLE).
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0; type 11 is always illegal.
//  Byte enables: byte -> 1<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100; word -> 1111.
//  wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> unchanged.
//  Load: s = data_rdata_i >> (8*offset); byte/half take s[7:0]/s[15:0], extended to 32
//    bits per latched sign_ext; word passes through. rdata_o=0 for stores and when valid_o=0.
//  rvalid in IDLE or WAIT_GNT (e.g. stale after reset) is ignored.
//  gnt in WAIT_RVALID is ignored.
//  Reset mid-access: returns to IDLE immediately; the outstanding response is dropped.
// TESTING
//  1. Word load at 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF
//     -> data_addr_o=0x100, be=1111, valid_o=1, rdata_o=0xDEADBEEF, busy_o low in rvalid cycle.
//  2. Signed byte load at 0x103, rdata 0x80112233 -> be=1000, rdata_o=0xFFFFFF80;
//     same access unsigned -> 0x00000080.
//  3. Half store 0xABCD at 0x202, gnt delayed 3 cycles -> data_req_o high 4 cycles,
//     be=1100, wdata=0xABCDABCD stable throughout, busy_o high until rvalid.
//  4. Word load at 0x101 -> err_o pulses 1 cycle, data_req_o=0, busy_o=0, state stays IDLE.
//  5. rst_i asserted in WAIT_RVALID, late rvalid after release -> all outputs 0, valid_o
//     never asserted, next request proceeds normally.
//  6. Back-to-back loads with req_i held -> second data_req_o exactly one cycle after the
//     first valid_o.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory port sequencer: req/gnt/rvalid handshake, byte-lane steering,
// misalignment detection and load extraction. One access in flight at a time.
module data_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            type_i,
  input  logic                  sign_ext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

  state_e                state_q;
  logic                  we_q;
  logic [1:0]            type_q;
  logic                  sext_q;
  logic [1:0]            off_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] addr_q;

  logic                  misaligned;
  logic                  accept;
  logic [3:0]            be_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  always_comb begin
    misaligned = 1'b0;
    be_in      = 4'b0000;
    wdata_in   = wdata_i;
    unique case (type_i)
      2'b00: begin
        misaligned = (addr_i[1:0] != 2'b00);
        be_in      = 4'b1111;
      end
      2'b01: begin
        misaligned = addr_i[0];
        be_in      = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{wdata_i[7:0]}};
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = (state_q == StIdle) && req_i && !misaligned;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q    <= we_i;
            type_q  <= type_i;
            sext_q  <= sign_ext_i;
            off_q   <= addr_i[1:0];
            be_q    <= be_in;
            wdata_q <= wdata_in;
            addr_q  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            state_q <= data_gnt_i ? StWaitRvalid : StWaitGnt;
          end
        end
        StWaitGnt: if (data_gnt_i) state_q <= StWaitRvalid;
        StWaitRvalid: if (data_rvalid_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sub-word loads are shifted down to lane 0 before extension.
  always_comb begin
    shifted = data_rdata_i >> {off_q, 3'b000};
    unique case (type_q)
      2'b10:   load_ext = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = data_rdata_i;
    endcase
  end

  // Every output is gated by rst_i since the IDLE request path is combinational.
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_wdata_o = '0;
    valid_o      = 1'b0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    rdata_o      = '0;
    if (!rst_i) begin
      if (accept) begin
        data_req_o   = 1'b1;
        data_addr_o  = {addr_i[DATA_WIDTH-1:2], 2'b00};
        data_we_o    = we_i;
        data_be_o    = be_in;
        data_wdata_o = wdata_in;
        busy_o       = 1'b1;
      end else if (state_q == StWaitGnt) begin
        data_req_o   = 1'b1;
        data_addr_o  = addr_q;
        data_we_o    = we_q;
        data_be_o    = be_q;
        data_wdata_o = wdata_q;
        busy_o       = 1'b1;
      end else if (state_q == StWaitRvalid) begin
        valid_o = data_rvalid_i;
        busy_o  = !data_rvalid_i;
        if (data_rvalid_i && !we_q) rdata_o = load_ext;
      end
      err_o = (state_q == StIdle) && req_i && misaligned;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a transaction-level reference model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i, sign_ext_i;
  logic [1:0]  type_i;
  logic [31:0] addr_i, wdata_i, rdata_o, data_addr_o, data_wdata_o, data_rdata_i;
  logic        valid_o, busy_o, err_o, data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [3:0]  data_be_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .type_i(type_i),
    .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".req"}, {31'd0, data_req_o}, 32'd0);
    check_eq({tag, ".addr"}, data_addr_o, 32'd0);
    check_eq({tag, ".we"}, {31'd0, data_we_o}, 32'd0);
    check_eq({tag, ".be"}, {28'd0, data_be_o}, 32'd0);
    check_eq({tag, ".wdata"}, data_wdata_o, 32'd0);
    check_eq({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
    check_eq({tag, ".busy"}, {31'd0, busy_o}, 32'd0);
    check_eq({tag, ".err"}, {31'd0, err_o}, 32'd0);
    check_eq({tag, ".rdata"}, rdata_o, 32'd0);
  endtask

  function automatic int unsigned size_of(input logic [1:0] typ);
    return (typ == 2'd0) ? 4 : (typ == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] typ, input logic sext,
                                           input logic [31:0] addr, input logic [31:0] rd);
    int unsigned sz = size_of(typ);
    longint unsigned mask = (64'd1 << (8 * sz)) - 1;
    longint unsigned v = (longint'(rd) >> (8 * (addr % 4))) & mask;
    if (sext && sz < 4 && v >= (mask + 1) / 2) v = v + (64'hFFFF_FFFF - mask);
    return v[31:0];
  endfunction

  // Drives one access; gd/rd are cycles of grant/response delay.
  task automatic do_access(input logic we, input logic [1:0] typ, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gd, input int rd, input logic [31:0] rdat);
    int unsigned sz = size_of(typ);
    bit mis = (typ == 2'd3) || ((addr % sz) != 0);
    logic [3:0] be = 4'(((1 << sz) - 1) << (addr % 4));
    logic [31:0] ewd = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                       (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    logic [31:0] erd = we ? 32'd0 : ref_load(typ, sext, addr, rdat);
    req_i = 1'b1; we_i = we; type_i = typ; sign_ext_i = sext; addr_i = addr; wdata_i = wd;
    if (mis) begin
      data_gnt_i = 1'($urandom); data_rvalid_i = 1'b0;
      @(negedge clk);
      check_eq("mis.err", {31'd0, err_o}, 32'd1);
      check_eq("mis.req", {31'd0, data_req_o}, 32'd0);
      check_eq("mis.busy", {31'd0, busy_o}, 32'd0);
      tick();
      req_i = 1'b0;
      @(negedge clk);
      check_quiet("mis.after");
      tick();
      return;
    end
    for (int c = 0; c <= gd; c++) begin
      data_gnt_i = (c == gd);
      data_rvalid_i = 1'($urandom);
      data_rdata_i = $urandom;
      @(negedge clk);
      check_eq("gnt.req", {31'd0, data_req_o}, 32'd1);
      check_eq("gnt.addr", data_addr_o, {addr[31:2], 2'b00});
      check_eq("gnt.we", {31'd0, data_we_o}, {31'd0, we});
      check_eq("gnt.be", {28'd0, data_be_o}, {28'd0, be});
      check_eq("gnt.wdata", data_wdata_o, ewd);
      check_eq("gnt.busy", {31'd0, busy_o}, 32'd1);
      check_eq("gnt.valid", {31'd0, valid_o}, 32'd0);
      check_eq("gnt.err", {31'd0, err_o}, 32'd0);
      tick();
      if (c < gd) addr_i = $urandom;  // ignored while waiting for grant
    end
    for (int c = 0; c <= rd; c++) begin
      data_gnt_i = 1'($urandom);
      data_rvalid_i = (c == rd);
      data_rdata_i = (c == rd) ? rdat : $urandom;
      @(negedge clk);
      check_eq("rv.req", {31'd0, data_req_o}, 32'd0);
      check_eq("rv.be", {28'd0, data_be_o}, 32'd0);
      check_eq("rv.addr", data_addr_o, 32'd0);
      check_eq("rv.busy", {31'd0, busy_o}, {31'd0, c != rd});
      check_eq("rv.valid", {31'd0, valid_o}, {31'd0, c == rd});
      check_eq("rv.rdata", rdata_o, (c == rd) ? erd : 32'd0);
      tick();
    end
    data_rvalid_i = 1'b0;
    data_gnt_i = 1'b0;
  endtask

  task automatic idle_cycle();
    req_i = 1'b0;
    data_rvalid_i = 1'($urandom);
    @(negedge clk);
    check_quiet("idle");
    tick();
    data_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; type_i = 2'd0; sign_ext_i = 1'b0;
    addr_i = 32'h100; wdata_i = 32'h1234_5678; data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
    data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check_quiet("reset");
    tick();
    rst_i = 1'b0;
    idle_cycle();

    // Directed cases
    do_access(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, 0, 0, 32'hDEAD_BEEF);
    idle_cycle();
    do_access(1'b0, 2'd2, 1'b1, 32'h103, 32'd0, 0, 1, 32'h8011_2233);
    do_access(1'b0, 2'd2, 1'b0, 32'h103, 32'd0, 1, 0, 32'h8011_2233);
    do_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 3, 2, 32'h5555_5555);
    do_access(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, 0, 0, 32'd0);
    do_access(1'b0, 2'd1, 1'b1, 32'h301, 32'd0, 0, 0, 32'd0);
    do_access(1'b1, 2'd3, 1'b0, 32'h400, 32'd0, 0, 0, 32'd0);

    // Reset while waiting for the response; a late rvalid must be dropped.
    req_i = 1'b1; we_i = 1'b0; type_i = 2'd0; addr_i = 32'h500; data_gnt_i = 1'b1;
    data_rvalid_i = 1'b0;
    tick();
    data_gnt_i = 1'b0;
    #2 rst_i = 1'b1;
    data_rvalid_i = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid");
    tick();
    rst_i = 1'b0; req_i = 1'b0;
    @(negedge clk);
    check_quiet("late_rvalid");
    tick();
    data_rvalid_i = 1'b0;
    do_access(1'b0, 2'd1, 1'b1, 32'h602, 32'd0, 1, 1, 32'hF00F_1234);

    // Back-to-back with req held: second request lands the cycle after valid_o.
    do_access(1'b0, 2'd0, 1'b0, 32'h700, 32'd0, 0, 0, 32'h0BAD_F00D);
    do_access(1'b0, 2'd0, 1'b0, 32'h704, 32'd0, 0, 0, 32'hCAFE_0001);
    idle_cycle();

    for (int i = 0; i < 300; i++) begin
      do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
